// File: rtl/fcp_link_channel.sv
// fcp_link_channel: FCP transport channel between the switch FCP source and
// the injector FCP sink. Messages pass through a fixed-length delay pipe and
// then enter a receive FIFO drained with ready/valid. A message whose VC
// matches the FIFO tail may overwrite that tail (coalescing). Messages that
// find the FIFO full are dropped and counted.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   s_fcp_*              source message (no backpressure, one per cycle)
//   m_fcp_*              head-of-FIFO message with ready/valid handshake
//   clear_stats          one-cycle pulse zeroing counters, reloading high water
//   stat_*_count         rx / tx / drop / coalesce event counters
//   fifo_level           current FIFO occupancy
//   fifo_high_water      peak occupancy since reset or last clear
module fcp_link_channel #(
    parameter int unsigned QUEUE_INDEX_WIDTH = 5,
    parameter int unsigned STAT_WIDTH        = 32,
    parameter int unsigned LATENCY_CYCLES    = 4,
    parameter int unsigned FIFO_DEPTH        = 16,
    parameter int unsigned COALESCE_EN       = 1,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_fcp_valid,
    input  logic [QUEUE_INDEX_WIDTH-1:0]   s_fcp_vc,
    input  logic [STAT_WIDTH-1:0]          s_fcp_fccl,
    input  logic [STAT_WIDTH-1:0]          s_fcp_qlen,
    input  logic [STAT_WIDTH-1:0]          s_fcp_fccr,
    output logic                           m_fcp_valid,
    input  logic                           m_fcp_ready,
    output logic [QUEUE_INDEX_WIDTH-1:0]   m_fcp_vc,
    output logic [STAT_WIDTH-1:0]          m_fcp_fccl,
    output logic [STAT_WIDTH-1:0]          m_fcp_qlen,
    output logic [STAT_WIDTH-1:0]          m_fcp_fccr,
    input  logic                           clear_stats,
    output logic [CNT_WIDTH-1:0]           stat_rx_count,
    output logic [CNT_WIDTH-1:0]           stat_tx_count,
    output logic [CNT_WIDTH-1:0]           stat_drop_count,
    output logic [CNT_WIDTH-1:0]           stat_coalesce_count,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_high_water
);

    localparam int unsigned QW    = QUEUE_INDEX_WIDTH;
    localparam int unsigned SW    = STAT_WIDTH;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    // FIFO write candidate (delay pipe output or raw input)
    logic          cand_valid;
    logic [QW-1:0] cand_vc;
    logic [SW-1:0] cand_fccl;
    logic [SW-1:0] cand_qlen;
    logic [SW-1:0] cand_fccr;

    generate
        if (LATENCY_CYCLES == 0) begin : g_no_delay
            assign cand_valid = s_fcp_valid;
            assign cand_vc    = s_fcp_vc;
            assign cand_fccl  = s_fcp_fccl;
            assign cand_qlen  = s_fcp_qlen;
            assign cand_fccr  = s_fcp_fccr;
        end else begin : g_delay
            logic [LATENCY_CYCLES-1:0] pipe_valid;
            logic [QW-1:0]             pipe_vc   [LATENCY_CYCLES];
            logic [SW-1:0]             pipe_fccl [LATENCY_CYCLES];
            logic [SW-1:0]             pipe_qlen [LATENCY_CYCLES];
            logic [SW-1:0]             pipe_fccr [LATENCY_CYCLES];

            // Valid shift register; reset discards in-flight messages
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_valid <= '0;
                end else begin
                    pipe_valid[0] <= s_fcp_valid;
                    for (int i = 1; i < int'(LATENCY_CYCLES); i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                    end
                end
            end

            // Payload shift register; qualified by pipe_valid, so no reset
            always_ff @(posedge clk) begin
                pipe_vc[0]   <= s_fcp_vc;
                pipe_fccl[0] <= s_fcp_fccl;
                pipe_qlen[0] <= s_fcp_qlen;
                pipe_fccr[0] <= s_fcp_fccr;
                for (int i = 1; i < int'(LATENCY_CYCLES); i++) begin
                    pipe_vc[i]   <= pipe_vc[i-1];
                    pipe_fccl[i] <= pipe_fccl[i-1];
                    pipe_qlen[i] <= pipe_qlen[i-1];
                    pipe_fccr[i] <= pipe_fccr[i-1];
                end
            end

            assign cand_valid = pipe_valid[LATENCY_CYCLES-1];
            assign cand_vc    = pipe_vc[LATENCY_CYCLES-1];
            assign cand_fccl  = pipe_fccl[LATENCY_CYCLES-1];
            assign cand_qlen  = pipe_qlen[LATENCY_CYCLES-1];
            assign cand_fccr  = pipe_fccr[LATENCY_CYCLES-1];
        end
    endgenerate

    // FIFO storage and control state
    logic [QW-1:0]    mem_vc   [FIFO_DEPTH];
    logic [SW-1:0]    mem_fccl [FIFO_DEPTH];
    logic [SW-1:0]    mem_qlen [FIFO_DEPTH];
    logic [SW-1:0]    mem_fccr [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;

    logic             pop;
    logic [PTR_W-1:0] tail_ptr;
    logic             do_coal;
    logic             do_push;
    logic             do_drop;
    logic [LVL_W-1:0] count_next;

    // Write decision: coalesce, else push, else drop
    always_comb begin
        pop        = 1'b0;
        tail_ptr   = '0;
        do_coal    = 1'b0;
        do_push    = 1'b0;
        do_drop    = 1'b0;
        count_next = count;

        pop      = (count != '0) && m_fcp_ready;
        tail_ptr = wr_ptr - PTR_W'(1);
        // When the only entry is being popped the tail is leaving, so the
        // candidate must allocate a fresh entry instead of overwriting it.
        do_coal  = (COALESCE_EN != 0) && cand_valid && (count != '0) &&
                   (mem_vc[tail_ptr] == cand_vc) &&
                   !((count == LVL_W'(1)) && pop);
        do_push  = cand_valid && !do_coal &&
                   ((count < LVL_W'(FIFO_DEPTH)) || pop);
        do_drop  = cand_valid && !do_coal && !do_push;
        count_next = count + LVL_W'(do_push) - LVL_W'(pop);
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    // Entry storage; contents beyond count are don't-care, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_vc[wr_ptr]   <= cand_vc;
            mem_fccl[wr_ptr] <= cand_fccl;
            mem_qlen[wr_ptr] <= cand_qlen;
            mem_fccr[wr_ptr] <= cand_fccr;
        end else if (do_coal) begin
            mem_vc[tail_ptr]   <= cand_vc;
            mem_fccl[tail_ptr] <= cand_fccl;
            mem_qlen[tail_ptr] <= cand_qlen;
            mem_fccr[tail_ptr] <= cand_fccr;
        end
    end

    // Statistics; clear_stats wins over same-cycle events
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rx_count       <= '0;
            stat_tx_count       <= '0;
            stat_drop_count     <= '0;
            stat_coalesce_count <= '0;
            fifo_high_water     <= '0;
        end else if (clear_stats) begin
            stat_rx_count       <= '0;
            stat_tx_count       <= '0;
            stat_drop_count     <= '0;
            stat_coalesce_count <= '0;
            fifo_high_water     <= count;
        end else begin
            if (cand_valid) begin
                stat_rx_count <= stat_rx_count + CNT_WIDTH'(1);
            end
            if (pop) begin
                stat_tx_count <= stat_tx_count + CNT_WIDTH'(1);
            end
            if (do_drop) begin
                stat_drop_count <= stat_drop_count + CNT_WIDTH'(1);
            end
            if (do_coal) begin
                stat_coalesce_count <= stat_coalesce_count + CNT_WIDTH'(1);
            end
            if (count_next > fifo_high_water) begin
                fifo_high_water <= count_next;
            end
        end
    end

    // Head presentation; fields read as zero while empty
    assign m_fcp_valid = (count != '0);
    assign m_fcp_vc    = m_fcp_valid ? mem_vc[rd_ptr]   : '0;
    assign m_fcp_fccl  = m_fcp_valid ? mem_fccl[rd_ptr] : '0;
    assign m_fcp_qlen  = m_fcp_valid ? mem_qlen[rd_ptr] : '0;
    assign m_fcp_fccr  = m_fcp_valid ? mem_fccr[rd_ptr] : '0;
    assign fifo_level  = count;

endmodule
